// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared state encoding and defaults for the seqdet stream sequencer
package seqdet_pkg;

    localparam int DATA_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seqdet_rot_shreg.sv
// rtl/seqdet_rot_shreg.sv - rotate-left pattern register presenting its MSB as the serial bit
module seqdet_rot_shreg
    import seqdet_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] load_val,
    output logic              ser_out
);

    logic [DATA_W-1:0] shreg;

    // Clearing when a job ends makes the MSB (and so x) read 0 outside SHIFT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (clear) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= load_val;
        end else if (en) begin
            shreg <= {shreg[DATA_W-2:0], shreg[DATA_W-1]};
        end
    end

    assign ser_out = shreg[DATA_W-1];

endmodule

// File: rtl/seqdet_stream_ctrl.sv
// rtl/seqdet_stream_ctrl.sv - streams a repeated pattern word into seqdet and counts its matches
module seqdet_stream_ctrl
    import seqdet_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 8,
    parameter int REP_W  = 4,
    parameter int Z_LAT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [REP_W-1:0]  rep_n,
    input  logic              abort,
    output logic              x,
    output logic              det_rst,
    input  logic              z,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              ovf
);

    localparam int BIT_W = $clog2(DATA_W);

    state_t             state;
    logic [BIT_W-1:0]   bit_cnt;
    logic [REP_W-1:0]   pass_cnt;
    logic [REP_W-1:0]   passes;

    logic last_bit;
    logic last_pass;
    logic first_edge;
    logic sample_z;
    logic sh_load;
    logic sh_clear;
    logic sh_en;

    always_comb begin
        last_bit   = (bit_cnt == BIT_W'(DATA_W - 1));
        last_pass  = (pass_cnt == passes - REP_W'(1));
        first_edge = (bit_cnt == '0) && (pass_cnt == '0);
        sample_z   = 1'b0;
        // A registered detector lags by one bit: skip the first SHIFT edge, catch the tail in DRAIN.
        if (!abort) begin
            if (state == SHIFT) begin
                sample_z = (Z_LAT == 0) || !first_edge;
            end else if (state == DRAIN) begin
                sample_z = 1'b1;
            end
        end
        sh_load  = (state == IDLE) && start;
        sh_clear = (state == SHIFT) && (abort || (last_bit && last_pass));
        sh_en    = (state == SHIFT);
    end

    seqdet_rot_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .clear    (sh_clear),
        .en       (sh_en),
        .load_val (data_in),
        .ser_out  (x)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            pass_cnt  <= '0;
            passes    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            det_rst   <= 1'b0;
            match_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (sample_z && z) begin
                if (&match_cnt) begin
                    ovf <= 1'b1;
                end else begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        passes    <= (rep_n == '0) ? REP_W'(1) : rep_n;
                        bit_cnt   <= '0;
                        pass_cnt  <= '0;
                        match_cnt <= '0;
                        ovf       <= 1'b0;
                        busy      <= 1'b1;
                        det_rst   <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        det_rst <= 1'b0;
                    end else begin
                        bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
                        if (last_bit) begin
                            pass_cnt <= pass_cnt + REP_W'(1);
                        end
                        if (last_bit && last_pass) begin
                            if (Z_LAT == 1) begin
                                state <= DRAIN;
                            end else begin
                                state   <= DONE;
                                busy    <= 1'b0;
                                det_rst <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    state   <= abort ? IDLE : DONE;
                    busy    <= 1'b0;
                    det_rst <= 1'b0;
                    done    <= !abort;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
